// File: rtl/ir_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ir_rx_pkg                                                  |
// | Purpose : shared state encoding and sizing helpers for the IR frame  |
// |           receiver and its FIFO.                                     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ir_rx_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      CHECK = 3'd4
   } rx_state_t;

   // Payload bits between start and stop: Addr, ~Addr, Data, ~Data.
   function automatic int frame_bits(input int addr_w, input int data_w);
      return 2 * addr_w + 2 * data_w;
   endfunction

   // Bit-timer value at which the line is sampled (middle of the bit).
   function automatic int mid_tick(input int oversample);
      return oversample / 2 - 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ir_frame_receiver_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : ir_frame_receiver_if                                     |
// | Purpose   : serial input, key-queue handshake and status lines of    |
// |             the IR frame receiver.                                   |
// | Ports     : Serial (line in), Pop (consumer take), Valid/Tecla/Addr  |
// |             (queue head), FrameErr/Overflow (pulses), Busy.          |
// | Modports  : master = receiver, slave = front end + consumer.         |
// | Rev       : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
interface ir_frame_receiver_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              Serial;
   logic              Pop;
   logic              Valid;
   logic [DATA_W-1:0] Tecla;
   logic [ADDR_W-1:0] Addr;
   logic              FrameErr;
   logic              Overflow;
   logic              Busy;

   modport master (
      input  Serial, Pop,
      output Valid, Tecla, Addr, FrameErr, Overflow, Busy
   );

   modport slave (
      output Serial, Pop,
      input  Valid, Tecla, Addr, FrameErr, Overflow, Busy
   );
endinterface
`default_nettype wire

// File: rtl/ir_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ir_rx_fifo                                                 |
// | Purpose : synchronous FIFO for accepted frames; head read directly   |
// |           from registered storage.                                   |
// | Ports   : Clock, Reset (async active-low), i_push, i_pop, i_din,     |
// |           o_dout (head), o_full, o_empty.                            |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ir_rx_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  wire logic             Clock,
   input  wire logic             Reset,
   input  wire logic             i_push,
   input  wire logic             i_pop,
   input  wire logic [WIDTH-1:0] i_din,
   output logic      [WIDTH-1:0] o_dout,
   output logic                  o_full,
   output logic                  o_empty
);
   localparam int c_PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_PTR_W:0]   r_count;
   logic               w_do_pop;
   logic               w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (c_PTR_W + 1)'(DEPTH));
   assign o_dout    = r_mem[r_rd_ptr];
   // A pop frees a slot in the same cycle, so a full FIFO can still accept.
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
            r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
            2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: rtl/ir_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ir_frame_receiver                                          |
// | Purpose : oversampled IR frame decoder. Start bit, Addr, ~Addr,      |
// |           Data, ~Data (MSB first), stop bit; inverse checks,         |
// |           optional address filter, accepted frames queued in a FIFO. |
// | Ports   : Clock, Reset (async active-low, synchronised release),     |
// |           bus (master): Serial, Pop in; Valid, Tecla, Addr,          |
// |           FrameErr, Overflow, Busy out.                              |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ir_frame_receiver #(
   parameter int OVERSAMPLE  = 8,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int ADDR_FILTER = 0,
   parameter int MY_ADDR     = 0
) (
   input wire logic            Clock,
   input wire logic            Reset,
   ir_frame_receiver_if.master bus
);
   import ir_rx_pkg::*;

   localparam int c_FRAME_BITS = frame_bits(ADDR_W, DATA_W);
   localparam int c_CNT_W      = $clog2(OVERSAMPLE);
   localparam int c_IDX_W      = $clog2(c_FRAME_BITS);
   localparam int c_ENTRY_W    = ADDR_W + DATA_W;
   localparam logic [c_CNT_W-1:0] c_MID      = c_CNT_W'(mid_tick(OVERSAMPLE));
   localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(OVERSAMPLE - 1);
   localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_FRAME_BITS - 1);
   localparam logic [ADDR_W-1:0]  c_MY_ADDR  = ADDR_W'(MY_ADDR);

   logic [1:0]              r_rst_sync;
   logic                    w_rst_n;
   logic                    r_ser_meta, r_s, r_s_prev;
   rx_state_t               r_state, w_next_state;
   logic [c_CNT_W-1:0]      r_bit_cnt;
   logic [c_IDX_W-1:0]      r_bit_idx;
   logic [c_FRAME_BITS-1:0] r_shift;
   logic                    r_frame_err, r_overflow;
   logic                    w_fall, w_tick, w_shift_en;
   logic                    w_err_set, w_ovf_set, w_push;
   logic                    w_inv_ok, w_addr_drop, w_pop_eff;
   logic                    w_full, w_empty;
   logic [ADDR_W-1:0]       w_addr, w_naddr;
   logic [DATA_W-1:0]       w_data, w_ndata;
   logic [c_ENTRY_W-1:0]    w_dout;

   // Assertion is asynchronous; release is aligned to Clock.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end
   assign w_rst_n = r_rst_sync[1];

   assign w_fall = !r_s && r_s_prev;
   assign w_tick = (r_state != IDLE) && (r_bit_cnt == c_MID);

   assign w_addr  = r_shift[c_FRAME_BITS-1 -: ADDR_W];
   assign w_naddr = r_shift[c_FRAME_BITS-1-ADDR_W -: ADDR_W];
   assign w_data  = r_shift[2*DATA_W-1 -: DATA_W];
   assign w_ndata = r_shift[DATA_W-1:0];

   assign w_inv_ok    = (w_addr == ~w_naddr) && (w_data == ~w_ndata);
   assign w_addr_drop = (ADDR_FILTER != 0) && (w_addr != c_MY_ADDR);
   assign w_pop_eff   = bus.Pop && !w_empty;

   always_ff @(posedge Clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_ser_meta  <= 1'b1;
         r_s         <= 1'b1;
         r_s_prev    <= 1'b1;
         r_state     <= IDLE;
         r_bit_cnt   <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_ser_meta  <= bus.Serial;
         r_s         <= r_ser_meta;
         r_s_prev    <= r_s;
         r_state     <= w_next_state;
         r_frame_err <= w_err_set;
         r_overflow  <= w_ovf_set;
         // Held at 0 in IDLE so the falling edge starts the bit at count 0.
         if (r_state == IDLE || r_bit_cnt == c_CNT_MAX) r_bit_cnt <= '0;
         else                                           r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
         if (r_state != DATA) r_bit_idx <= '0;
         else if (w_shift_en) r_bit_idx <= r_bit_idx + c_IDX_W'(1);
         if (w_shift_en) r_shift <= {r_shift[c_FRAME_BITS-2:0], r_s};
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_shift_en   = 1'b0;
      w_err_set    = 1'b0;
      w_ovf_set    = 1'b0;
      w_push       = 1'b0;
      case (r_state)
         IDLE:  if (w_fall) w_next_state = START;
         START: if (w_tick) w_next_state = r_s ? IDLE : DATA;
         DATA:  if (w_tick) begin
                   w_shift_en = 1'b1;
                   if (r_bit_idx == c_LAST_IDX) w_next_state = STOP;
                end
         STOP:  if (w_tick) begin
                   w_err_set    = !r_s;
                   w_next_state = r_s ? CHECK : IDLE;
                end
         CHECK: begin
                   w_next_state = IDLE;
                   if (!w_inv_ok)                   w_err_set = 1'b1;
                   else if (w_addr_drop)            w_push    = 1'b0;
                   else if (w_full && !w_pop_eff)   w_ovf_set = 1'b1;
                   else                             w_push    = 1'b1;
                end
         default: w_next_state = IDLE;
      endcase
   end

   ir_rx_fifo #(
      .WIDTH (c_ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clock   (Clock),
      .Reset   (w_rst_n),
      .i_push  (w_push),
      .i_pop   (bus.Pop),
      .i_din   ({w_addr, w_data}),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign bus.Valid    = !w_empty;
   assign bus.Addr     = w_dout[c_ENTRY_W-1 -: ADDR_W];
   assign bus.Tecla    = w_dout[DATA_W-1:0];
   assign bus.FrameErr = r_frame_err;
   assign bus.Overflow = r_overflow;
   assign bus.Busy     = (r_state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_ir_frame_receiver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ir_frame_receiver                                       |
// | Purpose : directed self-checking bench for ir_frame_receiver; one    |
// |           unfiltered instance and one with the address filter on.    |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ir_frame_receiver;
   logic Clock = 1'b0;
   logic Reset;
   logic serial, sel_f, pop_a, pop_f;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 Clock = ~Clock;

   ir_frame_receiver_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
   ir_frame_receiver_if #(.ADDR_W(8), .DATA_W(8)) bus_f ();

   assign bus_a.Serial = sel_f ? 1'b1 : serial;
   assign bus_f.Serial = sel_f ? serial : 1'b1;
   assign bus_a.Pop    = pop_a;
   assign bus_f.Pop    = pop_f;

   ir_frame_receiver #(.OVERSAMPLE(8), .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4),
                       .ADDR_FILTER(0), .MY_ADDR(0))
      dut (.Clock(Clock), .Reset(Reset), .bus(bus_a));

   ir_frame_receiver #(.OVERSAMPLE(8), .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(4),
                       .ADDR_FILTER(1), .MY_ADDR(16))
      dut_f (.Clock(Clock), .Reset(Reset), .bus(bus_f));

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic drive_bit(input logic b, input int n);
      serial = b;
      repeat (n) step();
   endtask

   // Returns #1 after the edge that ends the stop-bit tick cycle, i.e. inside CHECK.
   task automatic send_frame(input logic [7:0] a, input logic [7:0] na,
                             input logic [7:0] d, input logic [7:0] nd, input logic stop);
      logic [31:0] bits;
      bits = {a, na, d, nd};
      drive_bit(1'b1, 4);
      drive_bit(1'b0, 8);
      for (int i = 31; i >= 0; i--) drive_bit(bits[i], 8);
      drive_bit(stop, 7);
      serial = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; serial = 1'b1; sel_f = 1'b0; pop_a = 1'b0; pop_f = 1'b0;
      repeat (4) step();
      Reset = 1'b0;
      repeat (2) step();
      @(negedge Clock);
      n_checks++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus_a.Valid); end
      n_checks++; if (bus_a.Tecla !== 8'h00) begin n_fail++; $display("FAIL reset_tecla: got %h want 00", bus_a.Tecla); end
      n_checks++; if (bus_a.Addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", bus_a.Addr); end
      n_checks++; if ({bus_a.FrameErr, bus_a.Overflow, bus_a.Busy} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b want 000", {bus_a.FrameErr, bus_a.Overflow, bus_a.Busy}); end
      step();
      Reset = 1'b1;
      repeat (4) step();
   endtask

   task automatic test_nominal();
      send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 1'b1);
      @(negedge Clock);
      n_checks++; if ({bus_a.Valid, bus_a.Busy} !== 2'b01) begin n_fail++; $display("FAIL nominal_check_cycle: valid,busy got %b want 01", {bus_a.Valid, bus_a.Busy}); end
      @(negedge Clock);
      n_checks++; if (bus_a.Valid !== 1'b1) begin n_fail++; $display("FAIL nominal_valid: got %b want 1", bus_a.Valid); end
      n_checks++; if (bus_a.Tecla !== 8'h45) begin n_fail++; $display("FAIL nominal_tecla: got %h want 45", bus_a.Tecla); end
      n_checks++; if (bus_a.Addr !== 8'h00) begin n_fail++; $display("FAIL nominal_addr: got %h want 00", bus_a.Addr); end
      n_checks++; if (bus_a.Busy !== 1'b0) begin n_fail++; $display("FAIL nominal_busy: got %b want 0", bus_a.Busy); end
      step();
      pop_a = 1'b1; step(); pop_a = 1'b0;
      @(negedge Clock);
      n_checks++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL nominal_pop_valid: got %b want 0", bus_a.Valid); end
      step();
      // Pop on an empty queue must not disturb it.
      pop_a = 1'b1; step(); pop_a = 1'b0;
      @(negedge Clock);
      n_checks++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_valid: got %b want 0", bus_a.Valid); end
      step();
   endtask

   task automatic test_bad_inverse();
      send_frame(8'h00, 8'hFF, 8'h45, 8'hBB, 1'b1);
      @(negedge Clock);
      n_checks++; if ({bus_a.FrameErr, bus_a.Busy} !== 2'b01) begin n_fail++; $display("FAIL badinv_check_cycle: err,busy got %b want 01", {bus_a.FrameErr, bus_a.Busy}); end
      @(negedge Clock);
      n_checks++; if (bus_a.FrameErr !== 1'b1) begin n_fail++; $display("FAIL badinv_err: got %b want 1", bus_a.FrameErr); end
      n_checks++; if ({bus_a.Valid, bus_a.Busy} !== 2'b00) begin n_fail++; $display("FAIL badinv_valid_busy: got %b want 00", {bus_a.Valid, bus_a.Busy}); end
      @(negedge Clock);
      n_checks++; if (bus_a.FrameErr !== 1'b0) begin n_fail++; $display("FAIL badinv_err_width: got %b want 0", bus_a.FrameErr); end
      step();
   endtask

   task automatic test_stop_err();
      send_frame(8'h00, 8'hFF, 8'h45, 8'hBA, 1'b0);
      @(negedge Clock);
      n_checks++; if (bus_a.FrameErr !== 1'b1) begin n_fail++; $display("FAIL stop_err: got %b want 1", bus_a.FrameErr); end
      @(negedge Clock);
      n_checks++; if (bus_a.FrameErr !== 1'b0) begin n_fail++; $display("FAIL stop_err_width: got %b want 0", bus_a.FrameErr); end
      n_checks++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL stop_err_valid: got %b want 0", bus_a.Valid); end
      step();
   endtask

   task automatic test_glitch();
      logic busy_seen, err_seen;
      busy_seen = 1'b0; err_seen = 1'b0;
      drive_bit(1'b1, 4);
      drive_bit(1'b0, 2);
      serial = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge Clock);
         if (bus_a.Busy === 1'b1) busy_seen = 1'b1;
         if (bus_a.FrameErr !== 1'b0) err_seen = 1'b1;
      end
      n_checks++; if (busy_seen !== 1'b1) begin n_fail++; $display("FAIL glitch_start: busy seen %b want 1", busy_seen); end
      n_checks++; if (err_seen !== 1'b0) begin n_fail++; $display("FAIL glitch_err: err seen %b want 0", err_seen); end
      n_checks++; if ({bus_a.Busy, bus_a.Valid} !== 2'b00) begin n_fail++; $display("FAIL glitch_idle: busy,valid got %b want 00", {bus_a.Busy, bus_a.Valid}); end
      step();
   endtask

   task automatic test_addr_filter();
      sel_f = 1'b1;
      send_frame(8'h20, 8'hDF, 8'h07, 8'hF8, 1'b1);
      @(negedge Clock); @(negedge Clock);
      n_checks++; if ({bus_f.Valid, bus_f.FrameErr} !== 2'b00) begin n_fail++; $display("FAIL filter_drop: valid,err got %b want 00", {bus_f.Valid, bus_f.FrameErr}); end
      step();
      send_frame(8'h10, 8'hEF, 8'h07, 8'hF8, 1'b1);
      @(negedge Clock); @(negedge Clock);
      n_checks++; if (bus_f.Valid !== 1'b1) begin n_fail++; $display("FAIL filter_pass_valid: got %b want 1", bus_f.Valid); end
      n_checks++; if ({bus_f.Addr, bus_f.Tecla} !== 16'h1007) begin n_fail++; $display("FAIL filter_pass_data: got %h want 1007", {bus_f.Addr, bus_f.Tecla}); end
      step();
      pop_f = 1'b1; step(); pop_f = 1'b0;
      sel_f = 1'b0;
   endtask

   task automatic pop_and_check(input int first, input string tag);
      logic [7:0] exp_d;
      for (int i = first; i < first + 4; i++) begin
         exp_d = 8'(i * 17);
         @(negedge Clock);
         n_checks++; if ({bus_a.Valid, bus_a.Addr, bus_a.Tecla} !== {1'b1, 8'(i), exp_d}) begin n_fail++; $display("FAIL %s_pop%0d: got v=%b a=%h d=%h want v=1 a=%h d=%h", tag, i, bus_a.Valid, bus_a.Addr, bus_a.Tecla, 8'(i), exp_d); end
         pop_a = 1'b1; step(); pop_a = 1'b0;
      end
      @(negedge Clock);
      n_checks++; if (bus_a.Valid !== 1'b0) begin n_fail++; $display("FAIL %s_drained: valid got %b want 0", tag, bus_a.Valid); end
      step();
   endtask

   task automatic test_fifo_overflow();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), ~8'(i), 8'(i * 17), ~8'(i * 17), 1'b1);
      @(negedge Clock);
      @(negedge Clock);
      n_checks++; if (bus_a.Overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b want 1", bus_a.Overflow); end
      @(negedge Clock);
      n_checks++; if (bus_a.Overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_width: got %b want 0", bus_a.Overflow); end
      step();
      pop_and_check(1, "ovf");
   endtask

   task automatic test_pop_in_check();
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), ~8'(i), 8'(i * 17), ~8'(i * 17), 1'b1);
         if (i == 5) pop_a = 1'b1;
      end
      step();
      pop_a = 1'b0;
      @(negedge Clock);
      n_checks++; if (bus_a.Overflow !== 1'b0) begin n_fail++; $display("FAIL popcheck_no_ovf: got %b want 0", bus_a.Overflow); end
      step();
      pop_and_check(2, "popcheck");
   endtask

   task automatic test_reset_mid_frame();
      logic [31:0] bits;
      send_frame(8'h03, 8'hFC, 8'h66, 8'h99, 1'b1);
      send_frame(8'h03, 8'hFC, 8'h77, 8'h88, 1'b1);
      bits = {8'h05, 8'hFA, 8'h12, 8'hED};
      drive_bit(1'b1, 4);
      drive_bit(1'b0, 8);
      for (int i = 31; i > 21; i--) drive_bit(bits[i], 8);
      drive_bit(bits[21], 3);
      @(negedge Clock);
      n_checks++; if ({bus_a.Valid, bus_a.Busy} !== 2'b11) begin n_fail++; $display("FAIL midrst_pre: valid,busy got %b want 11", {bus_a.Valid, bus_a.Busy}); end
      Reset = 1'b0;
      serial = 1'b1;
      #1;
      n_checks++; if ({bus_a.Valid, bus_a.Busy, bus_a.Tecla} !== 10'h000) begin n_fail++; $display("FAIL midrst_clear: valid=%b busy=%b tecla=%h want 0 0 00", bus_a.Valid, bus_a.Busy, bus_a.Tecla); end
      step(); step();
      Reset = 1'b1;
      repeat (4) step();
      send_frame(8'h05, 8'hFA, 8'h12, 8'hED, 1'b1);
      @(negedge Clock); @(negedge Clock);
      n_checks++; if ({bus_a.Valid, bus_a.Addr, bus_a.Tecla} !== {1'b1, 16'h0512}) begin n_fail++; $display("FAIL midrst_after: got v=%b a=%h d=%h want v=1 a=05 d=12", bus_a.Valid, bus_a.Addr, bus_a.Tecla); end
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_nominal();
      test_bad_inverse();
      test_stop_err();
      test_glitch();
      test_addr_filter();
      test_fifo_overflow();
      test_pop_in_check();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ir_frame_receiver.md
Name: ir_frame_receiver

Overview:
- Parametrised successor of the 38 kHz remote-control serial receiver: oversampled, mid-bit-sampled frame decoder with start/stop framing.
- Checks both address and data fields against their inverses and optionally filters on a device address.
- Queues accepted key codes in an output FIFO with a Valid/Pop handshake, so the consumer no longer has to catch a fixed-length Ready pulse.
- Sits between the IR front end (Serial) and the key-handling logic.

Parameters:
- OVERSAMPLE, 8, Clock cycles per serial bit; even, ≥4.
- ADDR_W, 8, address field width.
- DATA_W, 8, key-code field width.
- FIFO_DEPTH, 4, accepted-frame queue depth; power of two, ≥2.
- ADDR_FILTER, 0, 1 = drop frames whose address ≠ MY_ADDR.
- MY_ADDR, 0, device address used when ADDR_FILTER=1.

Ports:
- Clock  in  1  system clock (OVERSAMPLE × bit rate).
- Reset  in  1  asynchronous, active-low reset.
- Serial  in  1  raw IR data line, idle high, asynchronous to Clock.
- Pop  in  1  consumer takes the head entry when Valid=1.
- Valid  out  1  FIFO not empty.
- Tecla  out  DATA_W  key code at the FIFO head.
- Addr  out  ADDR_W  address at the FIFO head.
- FrameErr  out  1  one-cycle pulse: stop-bit or inverse-check failure.
- Overflow  out  1  one-cycle pulse: good frame dropped because FIFO full.
- Busy  out  1  receiver state ≠ IDLE.

Behaviour:
- Reset: one clock, asynchronous, active-low; all flops clear on assertion and release synchronously through a 2-flop reset synchroniser.
  - Serial synchroniser flops reset to 1; FSM resets to IDLE.
  - FIFO resets empty; Valid=0, Tecla=0, Addr=0, FrameErr=0, Overflow=0, Busy=0.
- Input conditioning: Serial passes a 2-flop synchroniser, giving `s`. A falling edge is `s`=0 while the previous `s`=1.
- Frame format: 1 start bit (0), then 2·ADDR_W+2·DATA_W bits MSB-first, then 1 stop bit (1).
  - Field order is Addr, ~Addr, Data, ~Data.
  - Default frame is 32 data bits.
- Bit timer: count 0..OVERSAMPLE-1.
  - Loads 0 on the falling edge in IDLE and wraps to 0 after OVERSAMPLE-1.
  - Sample tick fires at count = OVERSAMPLE/2-1 (mid-bit).
- FSM states: IDLE, START, DATA, STOP, CHECK.
  - IDLE → START on falling edge.
  - START at first tick:
    - `s`=1 → IDLE (glitch, silent, no FrameErr).
    - `s`=0 → DATA.
  - DATA: each tick shifts `s` into the shift register and increments the bit counter. After the last data bit → STOP.
  - STOP at tick:
    - `s`=0 → FrameErr pulse, then IDLE.
    - `s`=1 → CHECK.
  - CHECK (exactly one cycle) → IDLE.
    - Inverse mismatch on either field → FrameErr pulse.
    - Else, ADDR_FILTER=1 and Addr≠MY_ADDR → silent drop.
    - Else, FIFO full and no Pop this cycle → Overflow pulse, frame dropped.
    - Else push {Addr, Data}.
- Falling edges outside IDLE are ignored. No re-sync mid-frame.
- Latency: the push happens at the end of the CHECK cycle, so Valid rises 2 cycles after the stop-bit sample tick.
- FIFO behaviour:
  - Head outputs (Tecla, Addr) come from registered storage.
  - Pop with Valid=0 is ignored.
  - Push and Pop in the same cycle when full: both occur, occupancy unchanged, no Overflow.
  - Push and Pop when count=1: new entry becomes head, Valid stays 1.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - Count is log2(FIFO_DEPTH)+1 bits.
- FrameErr and Overflow are registered pulses, asserted exactly one cycle.
- Reset asserted mid-frame: FSM returns to IDLE immediately and FIFO contents are lost.

Decomposition:
- Shared package ir_rx_pkg:
  - state enum (IDLE, START, DATA, STOP, CHECK);
  - FRAME_BITS = 2·ADDR_W + 2·DATA_W;
  - helper to compute the mid-bit tick constant.
- Sub-module ir_rx_fifo: parametrised synchronous FIFO (width ADDR_W+DATA_W, depth FIFO_DEPTH) with push/pop/full/empty.
- The decoder FSM, bit timer and shift register stay in ir_frame_receiver.

Test Plan:
- Nominal frame (OVERSAMPLE=8): Addr 0x00, Data 0x45, frame bits 0x00FF45BA, stop=1.
  - Expect Valid=1, Tecla=0x45, Addr=0x00, exactly 2 cycles after the stop sample tick.
  - Pop → Valid=0.
- Bad inverse: data 0x45 with ~Data sent as 0xBB.
  - Expect one FrameErr pulse, Valid stays 0, Busy drops the cycle after CHECK.
- Framing and glitch:
  - Stop bit driven 0 → FrameErr, no push.
  - 2-cycle low glitch on idle line → START returns to IDLE, no FrameErr, no push.
- Address filter (ADDR_FILTER=1, MY_ADDR=0x10):
  - Frame with Addr 0x20 → silently dropped.
  - Frame with Addr 0x10, Data 0x07 → pushed, Tecla=0x07.
- FIFO stress (FIFO_DEPTH=4): 5 good frames, no Pop.
  - Frames 1–4 queued; frame 5 → Overflow pulse.
  - 4 Pops return data in order.
  - Repeat with Pop asserted in the CHECK cycle of frame 5 → no Overflow, frame 5 queued.
- Reset mid-frame: drive Reset=0 during DATA bit 10 with 2 entries queued.
  - Expect Valid=0, Busy=0, Tecla=0 immediately.
  - After release, a full good frame decodes normally.
